// File: rtl/result_collect_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the result collect arbiter
// and its dispatch-side twin.
package result_collect_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  localparam int PKT_CNT_W = 32;
  localparam int RR_MAX_CH = 64;

  // First set bit of valid at or after ptr, wrapping at ch; returns 0 when none is set.
  function automatic int rr_pick(input logic [RR_MAX_CH-1:0] valid, input int ptr, input int ch);
    int idx;
    int pick;
    bit found;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < RR_MAX_CH; i++) begin
      if (i < ch) begin
        idx = ptr + i;
        if (idx >= ch) idx = idx - ch;
        if (!found && valid[idx[$clog2(RR_MAX_CH)-1:0]]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/result_collect_arbiter_if.sv
// Per-engine result channels in, one merged tagged stream out.
// The arbiter uses the slave modport; the engines/writeback side use master.
interface result_collect_arbiter_if
  import result_collect_pkg::*;
#(
  parameter int CH = 16,
  parameter int DW = 512
);
  localparam int CW = $clog2(CH);

  logic [CH-1:0][DW-1:0] ri_data;
  logic [CH-1:0]         ri_valid;
  logic [CH-1:0]         ri_last;
  logic [CH-1:0]         ri_ready;
  logic [DW-1:0]         ro_data;
  logic                  ro_last;
  logic [CW-1:0]         ro_ch;
  logic                  ro_valid;
  logic                  ro_ready;
`ifdef RESULT_COLLECT_PKT_CNT_EN
  logic [CH-1:0][PKT_CNT_W-1:0] pkt_cnt;

  modport master (
    output ri_data, ri_valid, ri_last, ro_ready,
    input  ri_ready, ro_data, ro_last, ro_ch, ro_valid, pkt_cnt
  );

  modport slave (
    input  ri_data, ri_valid, ri_last, ro_ready,
    output ri_ready, ro_data, ro_last, ro_ch, ro_valid, pkt_cnt
  );
`else
  modport master (
    output ri_data, ri_valid, ri_last, ro_ready,
    input  ri_ready, ro_data, ro_last, ro_ch, ro_valid
  );

  modport slave (
    input  ri_data, ri_valid, ri_last, ro_ready,
    output ri_ready, ro_data, ro_last, ro_ch, ro_valid
  );
`endif

endinterface

// File: rtl/result_collect_arbiter_rr_picker.sv
// Combinational CH-wide round-robin priority encoder; shared with the read dispatcher.
module rr_picker
  import result_collect_pkg::*;
#(
  parameter int CH = 16
) (
  input  logic [CH-1:0]         i_valid,
  input  logic [$clog2(CH)-1:0] i_ptr,
  output logic [$clog2(CH)-1:0] o_pick,
  output logic                  o_any
);
  localparam int CW = $clog2(CH);

  logic [RR_MAX_CH-1:0] w_validExt;

  always_comb begin
    w_validExt          = '0;
    w_validExt[CH-1:0]  = i_valid;
    o_pick              = CW'(rr_pick(w_validExt, int'(i_ptr), CH));
    o_any               = |i_valid;
  end

endmodule

// File: rtl/result_collect_arbiter.sv
// Round-robin, packet-locked merge of CH engine result streams into one registered,
// channel-tagged output. Optional per-channel packet counters: RESULT_COLLECT_PKT_CNT_EN.
module result_collect_arbiter
  import result_collect_pkg::*;
#(
  parameter int CH = 16,
  parameter int DW = 512
) (
  input logic                    clk,
  input logic                    rst,
  result_collect_arbiter_if.slave bus
);
  localparam int CW = $clog2(CH);

  state_t        r_state;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_gnt;
  logic [DW-1:0] r_roData;
  logic          r_roLast;
  logic [CW-1:0] r_roCh;
  logic          r_roValid;

  logic [CW-1:0] w_pick;
  logic          w_any;
  logic          w_slotFree;
  logic          w_beatAcc;
  logic          w_pktDone;

  rr_picker #(.CH(CH)) uPicker (
    .i_valid (bus.ri_valid),
    .i_ptr   (r_ptr),
    .o_pick  (w_pick),
    .o_any   (w_any)
  );

  // ro_ready may only reach ri_ready; ri_valid only feeds registered state.
  always_comb begin
    w_slotFree   = ~r_roValid | bus.ro_ready;
    bus.ri_ready = '0;
    if (r_state == XFER) bus.ri_ready[r_gnt] = w_slotFree;
    w_beatAcc    = (r_state == XFER) & bus.ri_valid[r_gnt] & w_slotFree;
    w_pktDone    = w_beatAcc & bus.ri_last[r_gnt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_roData  <= '0;
      r_roLast  <= 1'b0;
      r_roCh    <= '0;
      r_roValid <= 1'b0;
    end else begin
      if (w_beatAcc) begin
        r_roData  <= bus.ri_data[r_gnt];
        r_roLast  <= bus.ri_last[r_gnt];
        r_roCh    <= r_gnt;
        r_roValid <= 1'b1;
      end else if (bus.ro_ready) begin
        r_roValid <= 1'b0;
      end

      case (r_state)
        ARB: begin
          if (w_any) begin
            r_gnt   <= w_pick;
            r_state <= XFER;
          end
        end
        XFER: begin
          // Hold the grant across valid gaps until the last beat is taken.
          if (w_pktDone) begin
            r_ptr   <= (r_gnt == CW'(CH - 1)) ? '0 : r_gnt + CW'(1);
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign bus.ro_data  = r_roData;
  assign bus.ro_last  = r_roLast;
  assign bus.ro_ch    = r_roCh;
  assign bus.ro_valid = r_roValid;

`ifdef RESULT_COLLECT_PKT_CNT_EN
  logic [CH-1:0][PKT_CNT_W-1:0] r_pktCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pktCnt <= '0;
    end else if (w_pktDone) begin
      r_pktCnt[r_gnt] <= r_pktCnt[r_gnt] + PKT_CNT_W'(1);
    end
  end

  assign bus.pkt_cnt = r_pktCnt;
`endif

endmodule

// File: tb/tb_result_collect_arbiter.sv
// Randomized bench for result_collect_arbiter: per-channel packet sources against a
// round-robin packet-order model, plus directed latency, wrap and reset scenarios.
`timescale 1ns/1ps
module tb_result_collect_arbiter;
  import result_collect_pkg::*;

  localparam int CH   = 16;
  localparam int DW   = 32;
  localparam int MAXB = 64;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    bit            last;
    int            cyc;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  result_collect_arbiter_if #(.CH(CH), .DW(DW)) bus ();

  result_collect_arbiter #(.CH(CH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] srcData [CH][MAXB];
  bit            srcLast [CH][MAXB];
  int            srcCnt  [CH];
  int            srcPos  [CH];
  beat_t         expList [$];
  int            modelPtr;
  int            modelCnt [CH];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearSources();
    for (int c = 0; c < CH; c++) begin
      srcCnt[c] = 0;
      srcPos[c] = 0;
    end
  endtask

  task automatic addPacket(input int ch, input int len);
    for (int b = 0; b < len; b++) begin
      if (srcCnt[ch] < MAXB) begin
        srcData[ch][srcCnt[ch]] = {8'(ch), 24'($urandom)};
        srcLast[ch][srcCnt[ch]] = (b == len - 1);
        srcCnt[ch]++;
      end
    end
  endtask

  // Whole packets in round-robin order from modelPtr; with an always-ready sink the
  // first beat shows at cycle 2, beats stream back to back, one bubble between packets.
  task automatic buildModel();
    int    pos [CH];
    int    cyc;
    int    c;
    int    idx;
    bit    found;
    bit    done;
    beat_t b;
    expList.delete();
    cyc = 0;
    for (int i = 0; i < CH; i++) pos[i] = srcPos[i];
    forever begin
      found = 1'b0;
      c     = 0;
      for (int k = 0; k < CH; k++) begin
        idx = (modelPtr + k) % CH;
        if (!found && pos[idx] < srcCnt[idx]) begin
          found = 1'b1;
          c     = idx;
        end
      end
      if (!found) break;
      cyc  = (expList.size() == 0) ? 2 : cyc + 2;
      done = 1'b0;
      while (!done) begin
        b.ch   = c;
        b.data = srcData[c][pos[c]];
        b.last = srcLast[c][pos[c]];
        b.cyc  = cyc;
        expList.push_back(b);
        pos[c]++;
        done = b.last;
        if (!done) cyc++;
      end
      modelCnt[c]++;
      modelPtr = (c + 1) % CH;
    end
  endtask

  task automatic driveInputs(input int readyMode, input int gapPct, input int cyc);
    bit has;
    bit mid;
    for (int c = 0; c < CH; c++) begin
      has = srcPos[c] < srcCnt[c];
      mid = has && srcPos[c] > 0 && !srcLast[c][srcPos[c] - 1];
      bus.ri_valid[c] = has && !(mid && ($urandom_range(0, 99) < gapPct));
      bus.ri_data[c]  = has ? srcData[c][srcPos[c]] : '0;
      bus.ri_last[c]  = has ? srcLast[c][srcPos[c]] : 1'b0;
    end
    case (readyMode)
      0:       bus.ro_ready = 1'b1;
      1:       bus.ro_ready = ($urandom_range(0, 3) != 0);
      default: bus.ro_ready = ((cyc % 3) == 0);
    endcase
  endtask

  task automatic applyReset();
    rst          = 1'b1;
    bus.ri_valid = '0;
    bus.ri_last  = '0;
    bus.ri_data  = '0;
    bus.ro_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    modelPtr = 0;
    for (int c = 0; c < CH; c++) modelCnt[c] = 0;
  endtask

  task automatic checkResetValues();
    checkOutput("rstRoValid", 64'(bus.ro_valid), 64'(0));
    checkOutput("rstRoData",  64'(bus.ro_data),  64'(0));
    checkOutput("rstRoLast",  64'(bus.ro_last),  64'(0));
    checkOutput("rstRoCh",    64'(bus.ro_ch),    64'(0));
    checkOutput("rstRiReady", 64'(bus.ri_ready), 64'(0));
`ifdef RESULT_COLLECT_PKT_CNT_EN
    for (int c = 0; c < CH; c++)
      checkOutput($sformatf("rstPktCnt%0d", c), 64'(bus.pkt_cnt[c]), 64'(0));
`endif
  endtask

  task automatic checkPktCnt();
`ifdef RESULT_COLLECT_PKT_CNT_EN
    for (int c = 0; c < CH; c++)
      checkOutput($sformatf("pktCnt%0d", c), 64'(bus.pkt_cnt[c]), 64'(modelCnt[c]));
`endif
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic applyStimulus(input int readyMode, input int gapPct, input bit timed, input int maxCycles);
    int            outIdx;
    int            inIdx;
    logic [CH-1:0] readyVec;
    logic [CH-1:0] accVec;
    beat_t         e;
    buildModel();
    outIdx = 0;
    inIdx  = 0;
    driveInputs(readyMode, gapPct, 0);
    for (int cyc = 0; cyc < maxCycles && outIdx < expList.size(); cyc++) begin
      @(negedge clk);
      readyVec = bus.ri_ready;
      if (readyVec != '0) begin
        if (inIdx < expList.size())
          checkOutput("readyOwner", 64'(readyVec), 64'(1) << expList[inIdx].ch);
        else
          checkOutput("readyAfterEnd", 64'(readyVec), 64'(0));
      end
      if (bus.ro_valid && !bus.ro_ready)
        checkOutput("bpReady", 64'(readyVec), 64'(0));
      accVec = readyVec & bus.ri_valid;
      if (bus.ro_valid && bus.ro_ready) begin
        if (outIdx < expList.size()) begin
          e = expList[outIdx];
          checkOutput("outCh",   64'(bus.ro_ch),   64'(e.ch));
          checkOutput("outData", 64'(bus.ro_data), 64'(e.data));
          checkOutput("outLast", 64'(bus.ro_last), 64'(e.last));
          if (timed) checkOutput("outCycle", 64'(cyc), 64'(e.cyc));
          outIdx++;
        end else begin
          checkOutput("extraBeat", 64'(bus.ro_valid), 64'(0));
        end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < CH; c++) begin
        if (accVec[c]) begin
          srcPos[c]++;
          inIdx++;
        end
      end
      driveInputs(readyMode, gapPct, cyc + 1);
    end
    checkOutput("allBeatsOut", 64'(outIdx), 64'(expList.size()));
    checkOutput("allBeatsIn",  64'(inIdx),  64'(expList.size()));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values while rst is held and every channel is requesting.
    rst          = 1'b1;
    bus.ri_valid = '1;
    bus.ri_last  = '1;
    bus.ri_data  = '0;
    bus.ro_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues();
    applyReset();

    // 4-beat packet on ch 3, then ch 2 and ch 5 together: ptr at 4 picks ch 5 first.
    clearSources();
    addPacket(3, 4);
    applyStimulus(0, 0, 1'b1, 100);
    clearSources();
    addPacket(2, 1);
    addPacket(5, 1);
    applyStimulus(0, 0, 1'b1, 100);

    // Every channel holds one single-beat packet from reset.
    applyReset();
    clearSources();
    for (int c = 0; c < CH; c++) addPacket(c, 1);
    applyStimulus(0, 0, 1'b1, 200);

    // Drive ptr to 15, then ch 15 and ch 0 compete across the wrap.
    clearSources();
    addPacket(14, 1);
    applyStimulus(0, 0, 1'b1, 100);
    clearSources();
    addPacket(15, 2);
    addPacket(0, 1);
    applyStimulus(0, 0, 1'b1, 100);

    // ch 2 3-beat packet with ch 5 waiting, sink pattern 1,0,0 repeating.
    applyReset();
    clearSources();
    addPacket(2, 3);
    addPacket(5, 2);
    applyStimulus(2, 0, 1'b0, 200);
    checkPktCnt();

    // One-cycle reset in the middle of a ch 7 packet, then a clean ch 1 packet.
    applyReset();
    clearSources();
    addPacket(7, 4);
    driveInputs(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.ri_valid = '0;
    @(posedge clk);
    @(negedge clk);
    checkResetValues();
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelPtr = 0;
    for (int c = 0; c < CH; c++) modelCnt[c] = 0;
    clearSources();
    addPacket(1, 3);
    applyStimulus(0, 0, 1'b1, 100);
    checkPktCnt();

    // Three packets on ch 4 and one on ch 9 under random backpressure.
    applyReset();
    clearSources();
    for (int p = 0; p < 3; p++) addPacket(4, $urandom_range(1, 4));
    addPacket(9, 2);
    applyStimulus(1, 0, 1'b0, 500);
    checkPktCnt();

    // Random packet mixes with valid gaps and random or patterned backpressure.
    for (int r = 0; r < 6; r++) begin
      clearSources();
      for (int p = 0; p < $urandom_range(4, 12); p++)
        addPacket($urandom_range(0, CH - 1), $urandom_range(1, 4));
      applyStimulus($urandom_range(1, 2), 30, 1'b0, 2000);
      checkPktCnt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
